// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the multi-cycle ALU (alu_mc) and its iterative multiplier.
//   alu_op_e    : 4-bit opcode carried on ALUControl
//   alu_state_e : FSM state of alu_mc, also driven on its dbg_state output
//   alu_flags_t : NZCV-style flag bundle {zero, neg, carry, ovf}
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'b0000,
      OP_OR    = 4'b0001,
      OP_ADD   = 4'b0010,
      OP_SUB   = 4'b0110,
      OP_PASSB = 4'b0111,
      OP_MUL   = 4'b1000
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } alu_flags_t;

endpackage

// File: rtl/mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter
// Iterative shift-add multiplier returning the low N bits of a*b (unsigned).
// One multiplier bit is consumed per cycle, always N cycles per product
// (no early exit on zero operands).
//   clk, rst_n : clock, asynchronous active-low reset (aborts a running op)
//   start      : pulse; captures a/b and clears the accumulator
//   a, b       : operands, sampled only on start
//   done       : high during the final iteration cycle
//   product    : valid while done is high (includes the final iteration)
// ---------------------------------------------------------------------------
module mul_iter #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         done,
   output logic [N-1:0] product
);

   localparam int            CW   = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic          running;
   logic [CW-1:0] cnt;
   logic [N-1:0]  mcand;
   logic [N-1:0]  mplier;
   logic [N-1:0]  acc;
   logic [N-1:0]  acc_next;

   // Partial products above bit N-1 are shifted out of mcand and dropped,
   // which is exactly the truncation to the low N bits.
   assign acc_next = acc + (mplier[0] ? mcand : '0);

   // product is the accumulator after this cycle's step, so the consumer can
   // register it on the same edge that retires the last iteration.
   assign done    = running && (cnt == LAST);
   assign product = acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         mcand   <= a;
         mplier  <= b;
         acc     <= '0;
      end else if (running) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with valid/ready operand and result channels.
// Build option: define ALU_MUL_EN to support MUL (opcode 1000) through the
// iterative multiplier mul_iter; otherwise 1000 is treated as illegal and no
// multiplier logic exists.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low reset
//   in_valid    : operands/opcode present       in_ready : can accept
//   a, b        : N-bit operands                ALUControl : alu_op_e opcode
//   out_valid   : result/flags valid            out_ready  : consumer accepts
//   result      : registered N-bit result
//   zero, neg   : result==0 / result[N-1]
//   carry, ovf  : C and V flags for ADD/SUB, 0 otherwise
//   dbg_state   : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE with reset released; operands are
// captured on the accepting edge and later input changes are ignored.
// out_valid is high exactly in DONE; result/flags hold until out_ready is
// seen, then the block returns to IDLE. Ops never overlap, so peak
// throughput is one op every two cycles.
// ---------------------------------------------------------------------------
module alu_mc
   import alu_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   ALUControl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         zero,
   output logic         neg,
   output logic         carry,
   output logic         ovf,
   output alu_state_e   dbg_state
);

   alu_state_e state;
   alu_state_e state_next;
   alu_flags_t flags_q;

   logic         accept;
   logic         is_mul;
   logic         load_sc;
   logic         load_mul;
   logic         mul_start;
   logic         mul_done;
   logic [N-1:0] mul_product;

   // Single-cycle datapath
   logic         is_sub;
   logic [N-1:0] addend;
   logic [N:0]   sum;
   logic [N-1:0] sc_res;
   logic         sc_carry;
   logic         sc_ovf;

   assign accept    = in_valid && in_ready;
   assign in_ready  = (state == IDLE) && reset;
   assign out_valid = (state == DONE);
   assign dbg_state = state;

   assign zero  = flags_q.zero;
   assign neg   = flags_q.neg;
   assign carry = flags_q.carry;
   assign ovf   = flags_q.ovf;

   // SUB is a + ~b + 1, so carry-out set means no borrow.
   assign is_sub = (ALUControl == OP_SUB);
   assign addend = is_sub ? ~b : b;
   assign sum    = {1'b0, a} + {1'b0, addend} + {{N{1'b0}}, is_sub};

   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      case (ALUControl)
         OP_AND:   sc_res = a & b;
         OP_OR:    sc_res = a | b;
         OP_ADD,
         OP_SUB: begin
            sc_res   = sum[N-1:0];
            sc_carry = sum[N];
            // Same-sign inputs producing a different-sign sum overflowed.
            sc_ovf   = (a[N-1] == addend[N-1]) && (sum[N-1] != a[N-1]);
         end
         OP_PASSB: sc_res = b;
         default:  sc_res = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   assign is_mul = (ALUControl == OP_MUL);

   mul_iter #(
      .N (N)
   ) u_mul (
      .clk     (clk),
      .rst_n   (reset),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign is_mul      = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM: next state and load strobes
   always_comb begin
      state_next = state;
      load_sc    = 1'b0;
      load_mul   = 1'b0;
      mul_start  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  state_next = BUSY;
                  mul_start  = 1'b1;
               end else begin
                  state_next = DONE;
                  load_sc    = 1'b1;
               end
            end
         end
         BUSY: begin
            if (mul_done) begin
               state_next = DONE;
               load_mul   = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output registers; untouched while DONE waits on out_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result  <= '0;
         flags_q <= '0;
      end else if (load_sc) begin
         result        <= sc_res;
         flags_q.zero  <= (sc_res == '0);
         flags_q.neg   <= sc_res[N-1];
         flags_q.carry <= sc_carry;
         flags_q.ovf   <= sc_ovf;
      end else if (load_mul) begin
         result        <= mul_product;
         flags_q.zero  <= (mul_product == '0);
         flags_q.neg   <= mul_product[N-1];
         flags_q.carry <= 1'b0;
         flags_q.ovf   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc (N=64). Expectations track the ALU_MUL_EN
// build option: with it MUL returns the low product bits after N+1 cycles,
// without it opcode 1000 behaves as an illegal op.
// ---------------------------------------------------------------------------
module tb_alu_mc;
   import alu_pkg::*;

   localparam int N = 64;
   localparam int W = N + 4;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   ALUControl;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         zero;
   logic         neg;
   logic         carry;
   logic         ovf;
   alu_state_e   dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   alu_mc #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .neg        (neg),
      .carry      (carry),
      .ovf        (ovf),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Reference model: {result, zero, neg, carry, ovf} from plain arithmetic.
   function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [3:0] op);
      logic [N-1:0]      r;
      logic              c;
      logic              v;
      logic [2*N-1:0]    p;
      logic signed [N:0] sx;
      logic signed [N:0] sy;
      logic signed [N:0] s;
      r  = '0;
      c  = 1'b0;
      v  = 1'b0;
      sx = $signed({x[N-1], x});
      sy = $signed({y[N-1], y});
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b0010: begin
            {c, r} = {1'b0, x} + {1'b0, y};
            s = sx + sy;
            v = (s[N] != s[N-1]);   // true sum does not fit N signed bits
         end
         4'b0110: begin
            r = x - y;
            c = (x >= y);
            s = sx - sy;
            v = (s[N] != s[N-1]);
         end
         4'b0111: r = y;
         4'b1000: begin
            if (MUL_EN) begin
               p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
               r = p[N-1:0];
            end
         end
         default: r = '0;
      endcase
      return {r, (r == '0), r[N-1], c, v};
   endfunction

   function automatic int lat_of(input logic [3:0] op);
      return (MUL_EN && op == 4'b1000) ? N + 1 : 1;
   endfunction

   function automatic logic [N-1:0] rnd_operand();
      logic [N-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(N-1){1'b0}}};
         3:       v = N'($urandom_range(0, 255));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // ---------------- driver ----------------
   // Issues one op, checks latency and the popped expectation, optionally
   // holds out_ready low for 'hold' cycles, then retires the result.
   task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic [3:0] op,
                         input int hold, input string tag);
      logic [W-1:0] e;
      int guard;
      int lat;
      bit seen_ready;
      e = exp_q.pop_front();
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_in_ready"}, in_ready, 1'b1);
      a = x;
      b = y;
      ALUControl = op;
      in_valid = 1'b1;
      @(negedge clk);
      // Accepted on the edge just passed; scramble inputs to prove capture.
      in_valid = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      ALUControl = 4'($urandom_range(0, 15));
      lat = 1;
      seen_ready = 1'b0;
      while (!out_valid && lat < N + 20) begin
         if (in_ready) seen_ready = 1'b1;
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, lat_of(op));
      check({tag, "_busy_no_ready"}, seen_ready, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b1);
      check({tag, "_result"}, result, e[W-1:4]);
      check({tag, "_flags"}, {zero, neg, carry, ovf}, e[3:0]);
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
            check({tag, "_hold_result"}, {result, zero, neg, carry, ovf}, e);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_retire_valid"}, out_valid, 1'b0);
      check({tag, "_retire_in_ready"}, in_ready, 1'b1);
      out_ready = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]   op;
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic [N-1:0] res;
      logic [3:0]   fl;   // {zero, neg, carry, ovf}
      int           hold;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{4'b0010, 64'd5, 64'd3, 64'd8, 4'b0000, 0};
      tbl[1]  = '{4'b0110, 64'd3, 64'd3, 64'd0, 4'b1010, 0};
      tbl[2]  = '{4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 0};
      tbl[3]  = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101, 0};
      tbl[4]  = '{4'b1000, 64'd7, 64'd6, (MUL_EN ? 64'd42 : 64'd0),
                  (MUL_EN ? 4'b0000 : 4'b1000), 0};
      tbl[5]  = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 4'b0000, 5};
      tbl[6]  = '{4'b0001, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 0};
      tbl[7]  = '{4'b0111, 64'd9, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0100, 0};
      tbl[8]  = '{4'b0011, 64'hFF, 64'd1, 64'd0, 4'b1000, 0};
      tbl[9]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010, 0};
      tbl[10] = '{4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 0};
      tbl[11] = '{4'b1000, 64'd0, 64'h1234_5678, 64'd0, 4'b1000, 5};
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0] op;
      logic [N-1:0] x;
      logic [N-1:0] y;

      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      ALUControl = 4'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {out_valid, in_ready, result, zero, neg, carry, ovf}, '0);
      check("reset_state", dbg_state, IDLE);
      reset = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", in_ready, 1'b1);

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back({tbl[i].res, tbl[i].fl});
         run_op(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].hold, $sformatf("vec%0d", i));
      end

      // in_valid held through DONE: second op waits, then is taken
      a = 64'd10; b = 64'd20; ALUControl = 4'b0010; in_valid = 1'b1;
      @(negedge clk);
      a = 64'hF0; b = 64'h0F; ALUControl = 4'b0001;
      check("hold_first_valid", out_valid, 1'b1);
      check("hold_first_result", result, 64'd30);
      @(negedge clk);
      check("hold_off_in_ready", in_ready, 1'b0);
      check("hold_off_result", result, 64'd30);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hold_idle_valid", out_valid, 1'b0);
      check("hold_idle_in_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_second_valid", out_valid, 1'b1);
      check("hold_second_result", result, 64'hFF);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 6))
            0:       op = 4'b0000;
            1:       op = 4'b0001;
            2:       op = 4'b0010;
            3:       op = 4'b0110;
            4:       op = 4'b0111;
            5:       op = 4'b1000;
            default: op = 4'($urandom_range(0, 15));
         endcase
         x = rnd_operand();
         y = rnd_operand();
         exp_q.push_back(model(x, y, op));
         run_op(x, y, op, $urandom_range(0, 3), $sformatf("rnd%0d_op%0h", i, op));
      end

      // Reset in the middle of a MUL
      a = 64'd7; b = 64'd6; ALUControl = 4'b1000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("midreset_outputs", {out_valid, in_ready, result, zero, neg, carry, ovf}, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_in_ready", in_ready, 1'b1);
      check("midreset_no_result", out_valid, 1'b0);
      exp_q.push_back({64'h30, 4'b0000});
      run_op(64'hF0, 64'h3C, 4'b0000, 0, "after_reset_and");

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
